// File: rtl/nx_boot_loader_if.sv
// Load-stream port bundle for nx_boot_loader: valid/ready beats carrying channel, address and data.
// The master drives beats; the slave (the loader) returns s_ready.
interface nx_boot_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int NUM_CH = 3
) ();
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              s_valid;
  logic              s_ready;
  logic [CH_W-1:0]   s_ch;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  modport master (output s_valid, s_ch, s_addr, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_ch, s_addr, s_data, s_last, output s_ready);
endinterface

// File: rtl/nx_boot_loader.sv
// Boot loader: streams beats into inst RAM / data RAM / regfile, then releases core reset after a delay.
// Optional feature NX_BOOT_LOADER_CHECKSUM_EN adds an exp_sum input and a sticky sum_err output.
module nx_boot_loader #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_CH      = 3,
  parameter int RF_CH       = 2,
  parameter int RELEASE_CYC = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_start,
  nx_boot_loader_if.slave    s,
  output logic [NUM_CH-1:0]  wen,
  output logic [ADDR_W-1:0]  waddr,
  output logic [DATA_W-1:0]  wdata,
  output logic               core_rst,
  output logic               load_done,
  output logic               load_err,
  output logic [CNT_W-1:0]   beat_cnt
`ifdef NX_BOOT_LOADER_CHECKSUM_EN
  ,
  input  logic [DATA_W-1:0]  exp_sum,
  output logic               sum_err
`endif
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_CH-1:0]   wen_q, wen_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                load_err_q, load_err_d;
  logic                accept, ch_bad, rf_x0, keep, enter_load;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? v : v - 8'd1;
  endfunction

  always_comb begin
    accept     = s.s_valid && (state_q == LOAD);
    ch_bad     = int'(s.s_ch) >= NUM_CH;
    // Writes to x0 are silently discarded; the register is hardwired to zero.
    rf_x0      = (int'(s.s_ch) == RF_CH) && (s.s_addr[4:0] == 5'd0);
    keep       = accept && !ch_bad && !rf_x0;
    enter_load = load_start && ((state_q == IDLE) || (state_q == RUN));

    state_d    = state_q;
    cnt_d      = cnt_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    beat_cnt_d = beat_cnt_q;
    load_err_d = load_err_q;
    wen_d      = '0;

    for (int i = 0; i < NUM_CH; i++) begin
      wen_d[i] = keep && (int'(s.s_ch) == i);
    end

    if (accept) begin
      waddr_d = s.s_addr;
      wdata_d = s.s_data;
    end

    case (state_q)
      IDLE, RUN: begin
        if (enter_load) begin
          state_d    = LOAD;
          beat_cnt_d = '0;
          load_err_d = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          beat_cnt_d = sat_inc(beat_cnt_q);
          if (ch_bad) load_err_d = 1'b1;
          if (s.s_last) begin
            state_d = HOLD;
            cnt_d   = 8'(RELEASE_CYC);
          end
        end
      end
      HOLD: begin
        cnt_d = sat_dec(cnt_q);
        if (cnt_q <= 8'd1) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wen_q      <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      beat_cnt_q <= '0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      beat_cnt_q <= beat_cnt_d;
      load_err_q <= load_err_d;
    end
  end

  assign s.s_ready = (state_q == LOAD);
  assign wen       = wen_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign core_rst  = (state_q != RUN);
  assign load_done = (state_q == RUN);
  assign load_err  = load_err_q;
  assign beat_cnt  = beat_cnt_q;

`ifdef NX_BOOT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
  logic              sum_err_q, sum_err_d;

  // The verdict includes the final beat, so it is ready on the first HOLD cycle.
  always_comb begin
    sum_d     = sum_q;
    sum_err_d = sum_err_q;
    if (enter_load) begin
      sum_d     = '0;
      sum_err_d = 1'b0;
    end else if (accept) begin
      if (keep) sum_d = sum_q + s.s_data;
      if (s.s_last) sum_err_d = (sum_d != exp_sum);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q     <= '0;
      sum_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      sum_err_q <= sum_err_d;
    end
  end

  assign sum_err = sum_err_q;
`endif

endmodule

// File: tb/tb_nx_boot_loader.sv
// Bench for nx_boot_loader: directed vector tables, multi-cycle corner sequences and randomized loads
// checked every cycle against a timestamp-based transaction model.
module tb_nx_boot_loader;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int NUM_CH  = 3;
  localparam int RF_CH   = 2;
  localparam int RC      = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2;

  typedef struct {
    int                ch;
    logic [31:0]       addr;
    logic [31:0]       data;
    bit                last;
    int                gap;
    logic [NUM_CH-1:0] exp_wen;
  } vec_t;

  logic               clk = 1'b0;
  logic               rst, load_start;
  logic [NUM_CH-1:0]  wen;
  logic [ADDR_W-1:0]  waddr;
  logic [DATA_W-1:0]  wdata;
  logic               core_rst, load_done, load_err;
  logic [CNT_W-1:0]   beat_cnt;
`ifdef NX_BOOT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]  exp_sum;
  logic               sum_err;
  logic [DATA_W-1:0]  m_sum;
  bit                 m_sum_err;
`endif

  nx_boot_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) bif ();

  nx_boot_loader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH), .RF_CH(RF_CH),
    .RELEASE_CYC(RC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .s(bif.slave),
    .wen(wen), .waddr(waddr), .wdata(wdata), .core_rst(core_rst),
    .load_done(load_done), .load_err(load_err), .beat_cnt(beat_cnt)
`ifdef NX_BOOT_LOADER_CHECKSUM_EN
    , .exp_sum(exp_sum), .sum_err(sum_err)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0, n_total = 0;
  int cyc = 0, m_mode = M_IDLE, t_rel = 0, m_cnt = 0;
  bit m_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: decide the transaction outcome from the rules, then compare every output.
  task automatic tick(output bit acc);
    bit rst_p, ls_p, rel_p, last_p, bad, kept;
    int ch_p;
    logic [31:0] a_p, d_p;
    logic [NUM_CH-1:0] ew;
    rst_p  = rst;
    ls_p   = load_start;
    rel_p  = (m_mode == M_DONE) && (cyc >= t_rel);
    acc    = bif.s_valid && (m_mode == M_LOAD) && !rst_p;
    ch_p   = int'(bif.s_ch);
    a_p    = bif.s_addr;
    d_p    = bif.s_data;
    last_p = bif.s_last;
    ew     = '0;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_p) begin
      m_mode = M_IDLE; m_cnt = 0; m_err = 0;
`ifdef NX_BOOT_LOADER_CHECKSUM_EN
      m_sum = 0; m_sum_err = 0;
`endif
    end else if (ls_p && (m_mode == M_IDLE || rel_p)) begin
      m_mode = M_LOAD; m_cnt = 0; m_err = 0;
`ifdef NX_BOOT_LOADER_CHECKSUM_EN
      m_sum = 0; m_sum_err = 0;
`endif
    end else if (acc) begin
      bad  = ch_p >= NUM_CH;
      kept = !bad && !(ch_p == RF_CH && a_p[4:0] == 5'd0);
      if (kept) ew = NUM_CH'(1) << ch_p;
      if (bad) m_err = 1;
      if (m_cnt < CNT_MAX) m_cnt++;
`ifdef NX_BOOT_LOADER_CHECKSUM_EN
      if (kept) m_sum = m_sum + d_p;
`endif
      if (last_p) begin
        m_mode = M_DONE;
        t_rel  = cyc + RC;
`ifdef NX_BOOT_LOADER_CHECKSUM_EN
        m_sum_err = (m_sum != exp_sum);
`endif
      end
    end
    chk("wen", wen, ew);
    if (ew != 0) begin
      chk("waddr", waddr, a_p);
      chk("wdata", wdata, d_p);
    end
    chk("s_ready", bif.s_ready, m_mode == M_LOAD);
    chk("core_rst", core_rst, !(m_mode == M_DONE && cyc >= t_rel));
    chk("load_done", load_done, m_mode == M_DONE && cyc >= t_rel);
    chk("beat_cnt", beat_cnt, m_cnt);
    chk("load_err", load_err, m_err);
`ifdef NX_BOOT_LOADER_CHECKSUM_EN
    chk("sum_err", sum_err, m_sum_err);
`endif
  endtask

  task automatic idle(input int n);
    bit acc;
    bif.s_valid = 0;
    repeat (n) tick(acc);
  endtask

  task automatic start_load();
    bit acc;
    bif.s_valid = 0;
    load_start  = 1;
    tick(acc);
    load_start  = 0;
  endtask

  task automatic send_beat(input int ch, input logic [31:0] addr, input logic [31:0] data, input bit last);
    bit acc;
    acc         = 0;
    bif.s_valid = 1;
    bif.s_ch    = 2'(ch);
    bif.s_addr  = addr;
    bif.s_data  = data;
    bif.s_last  = last;
    for (int i = 0; i < 20 && !acc; i++) tick(acc);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic run_vec(input vec_t v);
    send_beat(v.ch, v.addr, v.data, v.last);
    chk("vec_wen", wen, v.exp_wen);
    if (v.exp_wen != 0) chk("vec_waddr", waddr, v.addr);
    if (v.gap > 0) idle(v.gap);
  endtask

  vec_t t28[3];
  vec_t t31[4];

  initial begin
    bit acc;
    int wen_cyc, rel_cyc, n;
    logic [31:0] a;

    t28[0] = '{0, 32'd0, 32'h0010_8133, 0, 0, 3'b001};
    t28[1] = '{2, 32'd1, 32'd38,        0, 0, 3'b100};
    t28[2] = '{2, 32'd2, 32'd22,        1, 0, 3'b100};
    t31[0] = '{0, 32'h100, 32'hA1, 0, 1, 3'b001};
    t31[1] = '{1, 32'h200, 32'hB2, 0, 1, 3'b010};
    t31[2] = '{2, 32'h003, 32'hC3, 0, 1, 3'b100};
    t31[3] = '{0, 32'h104, 32'hD4, 1, 0, 3'b001};

    rst = 1; load_start = 0;
    bif.s_valid = 0; bif.s_ch = '0; bif.s_addr = '0; bif.s_data = '0; bif.s_last = 0;
`ifdef NX_BOOT_LOADER_CHECKSUM_EN
    exp_sum = '0; m_sum = '0; m_sum_err = 0;
`endif
    tick(acc); tick(acc);
    rst = 0;
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_core_rst", core_rst, 1);
    idle(2);

    // Basic three-beat load and reset-release latency.
    start_load();
    for (int i = 0; i < 3; i++) run_vec(t28[i]);
    wen_cyc = cyc;
    chk("load_beat_cnt", beat_cnt, 3);
    bif.s_valid = 0;
    rel_cyc = -1;
    for (int i = 0; i < 12 && rel_cyc < 0; i++) begin
      tick(acc);
      if (core_rst === 1'b0) rel_cyc = cyc;
    end
    chk("release_delay", rel_cyc - wen_cyc, RC);
    chk("run_load_done", load_done, 1);

    // Out-of-range channel: dropped, sticky error into RUN, cleared by next load.
    start_load();
    send_beat(3, 32'h5, 32'h1234, 0);
    chk("badch_wen", wen, 0);
    chk("badch_err", load_err, 1);
    send_beat(0, 32'h4, 32'h7, 1);
    idle(RC + 1);
    chk("badch_err_run", load_err, 1);
    chk("badch_done", load_done, 1);
    start_load();
    chk("err_cleared", load_err, 0);

    // Regfile x0 write: dropped quietly, still counted.
    send_beat(2, 32'h0, 32'hDEAD_BEEF, 1);
    chk("x0_wen", wen, 0);
    chk("x0_err", load_err, 0);
    chk("x0_cnt", beat_cnt, 1);
    idle(RC + 1);

    // Gapped valid, then a load_start pulse during HOLD that must be ignored.
    start_load();
    for (int i = 0; i < 4; i++) run_vec(t31[i]);
    bif.s_valid = 0;
    load_start = 1;
    tick(acc);
    load_start = 0;
    chk("hold_ls_core_rst", core_rst, 1);
    chk("hold_ls_ready", bif.s_ready, 0);
    idle(RC + 1);
    chk("gap_cnt", beat_cnt, 4);
    chk("gap_done", load_done, 1);

    // Beat counter saturation.
    start_load();
    for (int i = 0; i < CNT_MAX + 3; i++) send_beat(1, 32'(i), 32'(i * 3), i == CNT_MAX + 2);
    chk("sat_cnt", beat_cnt, CNT_MAX);
    idle(RC + 1);

    // Reset on the same edge as an accept cancels the write.
    start_load();
    bif.s_valid = 1; bif.s_ch = 2'd0; bif.s_addr = 32'h40; bif.s_data = 32'h55; bif.s_last = 0;
    rst = 1;
    tick(acc);
    rst = 0; bif.s_valid = 0;
    chk("rstacc_wen", wen, 0);
    chk("rstacc_core_rst", core_rst, 1);
    chk("rstacc_waddr", waddr, 0);
    chk("rstacc_wdata", wdata, 0);
    chk("rstacc_cnt", beat_cnt, 0);
    chk("rstacc_ready", bif.s_ready, 0);
    idle(2);

    // Reset during HOLD aborts the release.
    start_load();
    send_beat(1, 32'h8, 32'h9, 1);
    bif.s_valid = 0;
    tick(acc);
    rst = 1;
    tick(acc);
    rst = 0;
    idle(RC + 2);
    chk("rsthold_core_rst", core_rst, 1);

`ifdef NX_BOOT_LOADER_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      exp_sum = (k == 0) ? 32'd6 : 32'd7;
      start_load();
      send_beat(0, 32'h4, 32'd1, 0);
      send_beat(1, 32'h8, 32'd2, 0);
      send_beat(0, 32'hC, 32'd3, 1);
      chk("sum_err_hold", sum_err, k);
      idle(RC + 1);
    end
`endif

    // Randomized loads.
    for (int l = 0; l < 12; l++) begin
`ifdef NX_BOOT_LOADER_CHECKSUM_EN
      exp_sum = $urandom_range(0, 1) ? 32'd0 : $urandom;
`endif
      start_load();
      n = $urandom_range(1, 6);
      for (int b = 0; b < n; b++) begin
        a = $urandom;
        if ($urandom_range(0, 3) == 0) a[4:0] = 5'd0;
        load_start = ($urandom_range(0, 3) == 0);
        send_beat($urandom_range(0, 3), a, $urandom, b == n - 1);
        load_start = 0;
        if (b != n - 1) idle($urandom_range(0, 2));
      end
      if ($urandom_range(0, 1) == 1) begin
        bif.s_valid = 0;
        load_start  = 1;
        tick(acc);
        load_start  = 0;
      end
      idle(RC + 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
